// File: rtl/oq_rr_input_arbiter.sv
// Packet-granular round-robin arbiter that merges NUM_INPUTS AXI4-Stream
// inputs onto the single slave port of the output-queue block.
//
// Ports:
//   axi_aclk, axi_resetn  : clock and synchronous active-low reset
//   s_axis_*              : packed per-input streams (input i in slice i)
//   m_axis_*              : merged stream towards the output queues
//   in_enable             : per-input arbitration mask, sampled only in IDLE
//   pkt_fwd               : one-cycle pulse per forwarded packet, per input
//   cur_grant             : one-hot owner of the output, zero in IDLE
module oq_rr_input_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_INPUTS           = 5
) (
    input  logic                                         axi_aclk,
    input  logic                                         axi_resetn,
    input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [NUM_INPUTS*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_INPUTS-1:0]                        s_axis_tvalid,
    input  logic [NUM_INPUTS-1:0]                        s_axis_tlast,
    output logic [NUM_INPUTS-1:0]                        s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]             m_axis_tstrb,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser,
    output logic                                         m_axis_tvalid,
    output logic                                         m_axis_tlast,
    input  logic                                         m_axis_tready,
    input  logic [NUM_INPUTS-1:0]                        in_enable,
    output logic [NUM_INPUTS-1:0]                        pkt_fwd,
    output logic [NUM_INPUTS-1:0]                        cur_grant
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int N  = NUM_INPUTS;
    localparam int IW = $clog2(NUM_INPUTS);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    grant;
    logic [N-1:0]    grant_nxt;
    logic [IW-1:0]   last;
    logic [IW-1:0]   last_nxt;
    logic [N-1:0]    fwd;
    logic [N-1:0]    fwd_nxt;
    logic [N-1:0]    req;
    logic [DW-1:0]   sel_data;
    logic [SW-1:0]   sel_strb;
    logic [UW-1:0]   sel_user;
    logic            sel_valid;
    logic            sel_last;
    logic            in_pkt;
    logic            accept;

    assign req    = s_axis_tvalid & in_enable;
    assign in_pkt = (state == PKT);

    // While a packet is in flight, last holds the owner's index, so it
    // doubles as the datapath mux select.
    always_comb begin
        sel_data  = '0;
        sel_strb  = '0;
        sel_user  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (last == IW'(i)) begin
                sel_data  = s_axis_tdata[i*DW +: DW];
                sel_strb  = s_axis_tstrb[i*SW +: SW];
                sel_user  = s_axis_tuser[i*UW +: UW];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    assign m_axis_tdata  = sel_data;
    assign m_axis_tstrb  = sel_strb;
    assign m_axis_tuser  = sel_user;
    assign m_axis_tvalid = in_pkt & sel_valid;
    assign m_axis_tlast  = in_pkt & sel_last;
    assign s_axis_tready = in_pkt ? (grant & {N{m_axis_tready}}) : '0;
    assign accept        = m_axis_tvalid & m_axis_tready;
    assign cur_grant     = grant;
    assign pkt_fwd       = fwd;

    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        fwd_nxt   = '0;
        found     = 1'b0;
        idx       = '0;
        unique case (state)
            IDLE: begin
                // Scan starting just after the previous winner.
                for (int k = 1; k <= N; k++) begin
                    idx = IW'((int'(last) + k) % N);
                    if (!found && req[idx]) begin
                        found          = 1'b1;
                        grant_nxt      = '0;
                        grant_nxt[idx] = 1'b1;
                        last_nxt       = idx;
                        state_nxt      = PKT;
                    end
                end
            end
            PKT: begin
                if (accept && m_axis_tlast) begin
                    fwd_nxt   = grant;
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(N - 1);
            fwd   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            fwd   <= fwd_nxt;
        end
    end

endmodule

// File: tb/tb_oq_rr_input_arbiter.sv
// Self-checking bench for oq_rr_input_arbiter: directed packet scenarios
// plus a long random run, checked against a round-robin packet model.
module tb_oq_rr_input_arbiter;

    localparam int N  = 5;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;

    logic clk = 1'b0;
    logic rstn;
    logic [N*DW-1:0] s_tdata;
    logic [N*SW-1:0] s_tstrb;
    logic [N*UW-1:0] s_tuser;
    logic [N-1:0]    tv;
    logic [N-1:0]    tl;
    logic [N-1:0]    s_trdy;
    logic [DW-1:0]   m_tdata;
    logic [SW-1:0]   m_tstrb;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_rdy;
    logic [N-1:0]    en;
    logic [N-1:0]    pkt_fwd;
    logic [N-1:0]    cur_grant;

    logic [DW-1:0] d  [N];
    logic [SW-1:0] st [N];
    logic [UW-1:0] u  [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_tdata[g*DW +: DW] = d[g];
        assign s_tstrb[g*SW +: SW] = st[g];
        assign s_tuser[g*UW +: UW] = u[g];
    end

    oq_rr_input_arbiter dut (
        .axi_aclk      (clk),
        .axi_resetn    (rstn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (tv),
        .s_axis_tlast  (tl),
        .s_axis_tready (s_trdy),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_rdy),
        .in_enable     (en),
        .pkt_fwd       (pkt_fwd),
        .cur_grant     (cur_grant)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Source state per input.
    int rem  [N];
    int pkts [N];
    int plen [N];
    int seq  [N];
    int nlast[N];
    bit hold [N];
    bit rnd;
    bit allow_new;

    // Observation state.
    int out_seq [N];
    int fwd_cnt [N];
    int fwd_log [$];
    bit rdy1_seen;
    bit armed;

    // Model state.
    int owner;
    int lastg;
    logic [N-1:0] fwd_exp;

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int pick(int lg, logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_all();
        for (int i = 0; i < N; i++) begin
            tv[i] = (rem[i] > 0) && !hold[i];
            tl[i] = (rem[i] == 1);
            d[i]  = '0;
            d[i][31:0] = {8'(i), 8'(rem[i]), 16'(seq[i])};
            d[i][DW-1 -: 32] = 32'hA500_0000 | 32'(seq[i]);
            u[i]  = '0;
            u[i][15:0] = 16'(seq[i]);
            u[i][UW-1] = 1'b1;
            st[i] = SW'(32'hFFFF_FFFF >> i);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            pkts[i] = 0;
            plen[i] = 1;
            hold[i] = 1'b0;
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = tv & s_trdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                seq[i]++;
                if (tl[i]) nlast[i]++;
                rem[i]--;
                if (rem[i] == 0 && pkts[i] > 0) begin
                    pkts[i]--;
                    rem[i] = plen[i];
                end
            end
        end
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && allow_new && $urandom_range(0, 2) == 0)
                    rem[i] = $urandom_range(1, 4);
                hold[i] = ($urandom_range(0, 9) < 3);
            end
            m_rdy = ($urandom_range(0, 3) != 0);
        end
        drive_all();
    endtask

    task automatic do_reset();
        clear_src();
        rstn = 1'b0;
        drive_all();
        step();
        step();
        rstn = 1'b1;
        drive_all();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (rem[i] > 0 || pkts[i] > 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Packet-level model: who owns the output and which pulse is due.
    always @(posedge clk) begin
        if (!rstn) begin
            owner   <= -1;
            lastg   <= N - 1;
            fwd_exp <= '0;
        end else if (owner < 0) begin
            fwd_exp <= '0;
            if (|(tv & en)) begin
                owner <= pick(lastg, tv & en);
                lastg <= pick(lastg, tv & en);
            end
        end else begin
            fwd_exp <= '0;
            if (tv[owner] && m_rdy && tl[owner]) begin
                fwd_exp <= N'(1 << owner);
                owner   <= -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] es;
        logic         ev;
        if (armed) begin
            eg = '0;
            es = '0;
            ev = 1'b0;
            if (owner >= 0) begin
                eg[owner] = 1'b1;
                es[owner] = m_rdy;
                ev = tv[owner];
            end
            chk("cur_grant", cur_grant, eg);
            chk("s_tready", s_trdy, es);
            chk("m_tvalid", m_tvalid, ev);
            chk("pkt_fwd", pkt_fwd, fwd_exp);
            if (ev) begin
                chk("m_tdata", m_tdata, d[owner]);
                chk("m_tstrb", m_tstrb, st[owner]);
                chk("m_tuser", m_tuser, u[owner]);
                chk("m_tlast", m_tlast, tl[owner]);
                if (m_rdy) begin
                    chk("beat_seq", m_tdata[15:0], 16'(out_seq[owner]));
                    out_seq[owner]++;
                end
            end
            if (s_trdy[1]) rdy1_seen = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (pkt_fwd[i]) begin
                    fwd_log.push_back(i);
                    fwd_cnt[i]++;
                end
            end
        end
    end

    initial begin
        int n;
        int c2;
        logic [6:0] pat;
        int exp3 [5];
        armed     = 1'b0;
        rnd       = 1'b0;
        allow_new = 1'b0;
        rdy1_seen = 1'b0;
        en        = '1;
        m_rdy     = 1'b1;
        for (int i = 0; i < N; i++) begin
            seq[i]     = 0;
            nlast[i]   = 0;
            out_seq[i] = 0;
            fwd_cnt[i] = 0;
        end
        do_reset();
        armed = 1'b1;

        // 1: one 3-beat packet on every input, served 0..4.
        fwd_log.delete();
        chk("t1_reset_grant", cur_grant, 5'b00000);
        chk("t1_reset_tready", s_trdy, 5'b00000);
        for (int i = 0; i < N; i++) rem[i] = 3;
        drive_all();
        n = 0;
        while (!all_empty() && n < 100) begin
            step();
            n++;
        end
        chk("t1_cycles", n, 20);
        step();
        step();
        chk("t1_nfwd", fwd_log.size(), 5);
        for (int i = 0; i < 5 && i < fwd_log.size(); i++)
            chk($sformatf("t1_order%0d", i), fwd_log[i], i);

        // 2: ten single-beat packets on input 2 alone.
        do_reset();
        fwd_log.delete();
        rem[2]  = 1;
        pkts[2] = 9;
        plen[2] = 1;
        drive_all();
        n = 0;
        while (!all_empty() && n < 100) begin
            step();
            n++;
        end
        chk("t2_cycles", n, 20);
        step();
        step();
        c2 = 0;
        foreach (fwd_log[k]) if (fwd_log[k] == 2) c2++;
        chk("t2_nfwd", fwd_log.size(), 10);
        chk("t2_fwd2", c2, 10);

        // 3: input 1 masked out.
        do_reset();
        fwd_log.delete();
        en = 5'b11101;
        rdy1_seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i]  = 1;
            pkts[i] = 3;
            plen[i] = 1;
        end
        drive_all();
        repeat (11) step();
        exp3 = '{0, 2, 3, 4, 0};
        chk("t3_nfwd", fwd_log.size(), 5);
        for (int i = 0; i < 5 && i < fwd_log.size(); i++)
            chk($sformatf("t3_order%0d", i), fwd_log[i], exp3[i]);
        chk("t3_rdy1", rdy1_seen, 1'b0);
        en = '1;

        // 4: stalls and a source gap inside input 3's packet.
        do_reset();
        fwd_log.delete();
        rem[3] = 4;
        rem[4] = 2;
        pat = 7'b1011001;
        for (int t = 0; t < 16; t++) begin
            m_rdy   = (t < 7) ? pat[6 - t] : 1'b1;
            hold[3] = (t == 4 || t == 5);
            drive_all();
            step();
        end
        chk("t4_nfwd", fwd_log.size(), 2);
        if (fwd_log.size() == 2) begin
            chk("t4_first", fwd_log[0], 3);
            chk("t4_second", fwd_log[1], 4);
        end
        m_rdy = 1'b1;

        // 5: reset in the middle of a packet from input 1.
        do_reset();
        fwd_log.delete();
        rem[1] = 5;
        drive_all();
        step();
        step();
        rstn = 1'b0;
        drive_all();
        step();
        chk("t5_grant", cur_grant, 5'b00000);
        chk("t5_fwd", pkt_fwd, 5'b00000);
        chk("t5_tready", s_trdy, 5'b00000);
        clear_src();
        rstn = 1'b1;
        rem[0] = 1;
        rem[1] = 2;
        drive_all();
        step();
        chk("t5_first", cur_grant, 5'b00001);
        step();
        chk("t5_nofwd", fwd_log.size(), 0);

        // 6: random traffic and back-pressure.
        do_reset();
        for (int i = 0; i < N; i++) begin
            nlast[i]   = 0;
            fwd_cnt[i] = 0;
        end
        rnd       = 1'b1;
        allow_new = 1'b1;
        repeat (10000) step();
        rnd       = 1'b0;
        allow_new = 1'b0;
        m_rdy     = 1'b1;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        drive_all();
        n = 0;
        while (!all_empty() && n < 200) begin
            step();
            n++;
        end
        chk("t6_drained", all_empty(), 1'b1);
        step();
        step();
        for (int i = 0; i < N; i++)
            chk($sformatf("t6_fwd_cnt%0d", i), fwd_cnt[i], nlast[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
